// File: rtl/xga_video_timing_if.sv
// Pixel-fetch bus between the video timing generator (master) and the
// framebuffer reader (slave): request coordinates out, RGB data back.
interface xga_video_timing_if;
    logic        pix_req;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_data;
    logic        frame_start;
    logic        line_start;

    modport master (
        output pix_req,
        output pix_x,
        output pix_y,
        output frame_start,
        output line_start,
        input  pix_data
    );

    modport slave (
        input  pix_req,
        input  pix_x,
        input  pix_y,
        input  frame_start,
        input  line_start,
        output pix_data
    );
endinterface

// File: rtl/xga_video_timing.sv
// XGA video timing generator and pixel-fetch sequencer: issues (x,y) requests,
// then drives VGA DAC pins with sync/blank delayed to line up with returned RGB.
module xga_video_timing #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int LATENCY  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pll_locked,
    xga_video_timing_if.master         pix,
    output logic                       vga_hs,
    output logic                       vga_vs,
    output logic                       vga_blank_n,
    output logic                       vga_sync_n,
    output logic [7:0]                 vga_r,
    output logic [7:0]                 vga_g,
    output logic [7:0]                 vga_b
);

    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG_C = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END_C = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST_C = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEG_C = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST_C = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // Losing PLL lock is treated exactly like a reset: the frame is abandoned.
    logic srst;
    assign srst = rst | ~pll_locked;

    logic [10:0] h_cnt_reg, h_cnt_next;
    logic [9:0]  v_cnt_reg, v_cnt_next;
    logic        active, hs_raw, vs_raw;

    always_comb begin
        h_cnt_next = h_cnt_reg + 11'd1;
        v_cnt_next = v_cnt_reg;
        if (h_cnt_reg == H_LAST_C) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST_C) ? '0 : v_cnt_reg + 10'd1;
        end
        active = (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
        hs_raw = (h_cnt_reg >= HS_BEG_C) && (h_cnt_reg < HS_END_C);
        vs_raw = (v_cnt_reg >= VS_BEG_C) && (v_cnt_reg < VS_END_C);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    // Stage 0: request register; sync flags are registered alongside so the
    // whole group shares one timing reference.
    logic        pix_req_reg;
    logic [10:0] pix_x_reg;
    logic [9:0]  pix_y_reg;
    logic        frame_start_reg, line_start_reg;
    logic        hs_raw_reg, vs_raw_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            pix_req_reg     <= 1'b0;
            pix_x_reg       <= '0;
            pix_y_reg       <= '0;
            frame_start_reg <= 1'b0;
            line_start_reg  <= 1'b0;
            hs_raw_reg      <= 1'b0;
            vs_raw_reg      <= 1'b0;
        end else begin
            pix_req_reg     <= active;
            if (active) begin
                pix_x_reg <= h_cnt_reg;
                pix_y_reg <= v_cnt_reg;
            end
            frame_start_reg <= (h_cnt_reg == '0) && (v_cnt_reg == '0);
            line_start_reg  <= (h_cnt_reg == '0) && (v_cnt_reg < V_ACT_C);
            hs_raw_reg      <= hs_raw;
            vs_raw_reg      <= vs_raw;
        end
    end

    assign pix.pix_req     = pix_req_reg;
    assign pix.pix_x       = pix_x_reg;
    assign pix.pix_y       = pix_y_reg;
    assign pix.frame_start = frame_start_reg;
    assign pix.line_start  = line_start_reg;

    // Delay line matching the framebuffer read latency.
    logic [LATENCY-1:0] de_sr_reg, de_sr_next;
    logic [LATENCY-1:0] hs_sr_reg, hs_sr_next;
    logic [LATENCY-1:0] vs_sr_reg, vs_sr_next;

    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_delay
        if (gi == 0) begin : g_head
            assign de_sr_next[gi] = pix_req_reg;
            assign hs_sr_next[gi] = hs_raw_reg;
            assign vs_sr_next[gi] = vs_raw_reg;
        end else begin : g_tail
            assign de_sr_next[gi] = de_sr_reg[gi-1];
            assign hs_sr_next[gi] = hs_sr_reg[gi-1];
            assign vs_sr_next[gi] = vs_sr_reg[gi-1];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            de_sr_reg <= '0;
            hs_sr_reg <= '0;
            vs_sr_reg <= '0;
        end else begin
            de_sr_reg <= de_sr_next;
            hs_sr_reg <= hs_sr_next;
            vs_sr_reg <= vs_sr_next;
        end
    end

    logic de_d, hs_d, vs_d;
    assign de_d = de_sr_reg[LATENCY-1];
    assign hs_d = hs_sr_reg[LATENCY-1];
    assign vs_d = vs_sr_reg[LATENCY-1];

    logic       vga_hs_reg, vga_vs_reg, vga_blank_n_reg;
    logic [7:0] vga_r_reg, vga_g_reg, vga_b_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            vga_hs_reg      <= ~H_POL;
            vga_vs_reg      <= ~V_POL;
            vga_blank_n_reg <= 1'b0;
            vga_r_reg       <= '0;
            vga_g_reg       <= '0;
            vga_b_reg       <= '0;
        end else begin
            vga_hs_reg      <= hs_d ? H_POL : ~H_POL;
            vga_vs_reg      <= vs_d ? V_POL : ~V_POL;
            vga_blank_n_reg <= de_d;
            vga_r_reg       <= de_d ? pix.pix_data[23:16] : 8'd0;
            vga_g_reg       <= de_d ? pix.pix_data[15:8]  : 8'd0;
            vga_b_reg       <= de_d ? pix.pix_data[7:0]   : 8'd0;
        end
    end

    assign vga_hs      = vga_hs_reg;
    assign vga_vs      = vga_vs_reg;
    assign vga_blank_n = vga_blank_n_reg;
    assign vga_sync_n  = 1'b0;
    assign vga_r       = vga_r_reg;
    assign vga_g       = vga_g_reg;
    assign vga_b       = vga_b_reg;

endmodule

// File: tb/tb_xga_video_timing.sv
// Directed bench for xga_video_timing: default XGA timing, LATENCY=3 data
// alignment, and a reduced-size instance for whole-frame timing.
module tb_xga_video_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default instance (LATENCY=2)
    logic rst0 = 1'b1, lock0 = 1'b1;
    logic hs0, vs0, bl0, sn0;
    logic [7:0] r0, g0, b0;
    xga_video_timing_if if0();

    xga_video_timing dut0 (
        .clk(clk), .rst(rst0), .pll_locked(lock0), .pix(if0),
        .vga_hs(hs0), .vga_vs(vs0), .vga_blank_n(bl0), .vga_sync_n(sn0),
        .vga_r(r0), .vga_g(g0), .vga_b(b0)
    );

    // LATENCY=3 instance for data alignment
    logic rst3 = 1'b1, lock3 = 1'b1;
    logic hs3, vs3, bl3, sn3;
    logic [7:0] r3, g3, b3;
    xga_video_timing_if if3();

    xga_video_timing #(.LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .pll_locked(lock3), .pix(if3),
        .vga_hs(hs3), .vga_vs(vs3), .vga_blank_n(bl3), .vga_sync_n(sn3),
        .vga_r(r3), .vga_g(g3), .vga_b(b3)
    );

    // Small instance: H 8/2/3/1 (H_TOT=14), V 4/1/2/1 (V_TOT=8)
    logic rsts = 1'b1, locks = 1'b1;
    logic hss, vss, bls, sns;
    logic [7:0] rs, gs, bs;
    xga_video_timing_if ifs();

    xga_video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .LATENCY(2)
    ) duts (
        .clk(clk), .rst(rsts), .pll_locked(locks), .pix(ifs),
        .vga_hs(hss), .vga_vs(vss), .vga_blank_n(bls), .vga_sync_n(sns),
        .vga_r(rs), .vga_g(gs), .vga_b(bs)
    );

    localparam int AL_N = 3000;
    logic        hist_req [0:AL_N-1];
    logic [10:0] hist_x   [0:AL_N-1];
    logic [9:0]  hist_y   [0:AL_N-1];

    function automatic logic [23:0] pat(input logic [10:0] x, input logic [9:0] y);
        return {x[7:0], y[7:0], 8'hA5};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_d0;
        rst0 = 1'b1;
        repeat (2) step();
        rst0 = 1'b0;
    endtask

    task automatic test_reset;
        rst0 = 1'b1;
        repeat (5) step();
        checks++;
        if ({hs0, vs0, bl0, sn0, r0, g0, b0} !== {1'b1, 1'b1, 1'b0, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL reset_pins: got hs=%b vs=%b blank_n=%b sync_n=%b rgb=%h, need 1 1 0 0 000000",
                     hs0, vs0, bl0, sn0, {r0, g0, b0});
        end
        checks++;
        if ({if0.pix_req, if0.pix_x, if0.pix_y, if0.frame_start, if0.line_start} !== 24'h0) begin
            errors++;
            $display("FAIL reset_req: got req=%b x=%0d y=%0d fs=%b ls=%b, need all 0",
                     if0.pix_req, if0.pix_x, if0.pix_y, if0.frame_start, if0.line_start);
        end
        rst0 = 1'b0;
        step();
        checks++;
        if ({if0.pix_req, if0.pix_x, if0.pix_y, if0.frame_start, if0.line_start} !== {1'b1, 21'h0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL first_req: got req=%b x=%0d y=%0d fs=%b ls=%b, need 1 0 0 1 1",
                     if0.pix_req, if0.pix_x, if0.pix_y, if0.frame_start, if0.line_start);
        end
    endtask

    task automatic test_line_timing;
        int req_hi = 0, req_lo = 0, ls_cnt = 0;
        int blank_rise = -1, hs_fall = -1, hs_rise = -1;
        logic prev_bl = 1'b0;
        reset_d0();
        for (int k = 0; k < 3 * 1344; k++) begin
            step();
            if (k < 1344) begin
                if (if0.pix_req === 1'b1) req_hi++;
                else req_lo++;
            end
            if (if0.line_start === 1'b1) ls_cnt++;
            if (blank_rise < 0 && prev_bl == 1'b0 && bl0 === 1'b1) blank_rise = k;
            if (hs_fall < 0 && hs0 === 1'b0) hs_fall = k;
            if (hs_fall >= 0 && hs_rise < 0 && hs0 === 1'b1) hs_rise = k;
            prev_bl = bl0;
            if (k == 3) begin
                checks++;
                if ({r0, g0, b0} !== 24'h123456) begin
                    errors++;
                    $display("FAIL first_rgb: got %h need 123456", {r0, g0, b0});
                end
            end
            if (k == 1100) begin
                checks++;
                if ({bl0, r0, g0, b0} !== 25'h0 || if0.pix_x !== 11'd1023 || if0.pix_req !== 1'b0) begin
                    errors++;
                    $display("FAIL hblank_hold: got blank_n=%b rgb=%h x=%0d req=%b need 0 000000 1023 0",
                             bl0, {r0, g0, b0}, if0.pix_x, if0.pix_req);
                end
            end
            if (k == 1344) begin
                checks++;
                if (if0.line_start !== 1'b1 || if0.pix_x !== 11'd0 || if0.pix_y !== 10'd1 || if0.frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL line1_start: got ls=%b x=%0d y=%0d fs=%b need 1 0 1 0",
                             if0.line_start, if0.pix_x, if0.pix_y, if0.frame_start);
                end
            end
        end
        checks++;
        if (req_hi !== 1024 || req_lo !== 320) begin
            errors++;
            $display("FAIL req_count: got high=%0d low=%0d need 1024 320", req_hi, req_lo);
        end
        checks++;
        if (blank_rise !== 3) begin
            errors++;
            $display("FAIL blank_rise: got cycle %0d need 3", blank_rise);
        end
        checks++;
        if (hs_fall - blank_rise !== 1048 || hs_rise - hs_fall !== 136) begin
            errors++;
            $display("FAIL hs_window: got offset=%0d width=%0d need 1048 136",
                     hs_fall - blank_rise, hs_rise - hs_fall);
        end
        checks++;
        if (ls_cnt !== 3) begin
            errors++;
            $display("FAIL line_start_count: got %0d need 3", ls_cnt);
        end
    endtask

    task automatic test_frame_timing;
        int fs_cnt = 0, fs_first = -1, fs_last = -1, ls_f0 = 0;
        int vs_fall = -1, vs_low = 0, bl_in_vs = 0, per_cycle_err = 0;
        rsts = 1'b1;
        repeat (2) step();
        rsts = 1'b0;
        for (int k = 0; k < 3 * 112; k++) begin
            int h, v, idx, ih, iv;
            logic exp_req, exp_fs, exp_ls, exp_bl, exp_hs, exp_vs;
            step();
            h = k % 14;
            v = (k / 14) % 8;
            exp_req = (h < 8) && (v < 4);
            exp_fs  = (k % 112) == 0;
            exp_ls  = (h == 0) && (v < 4);
            idx = k - 3;
            if (idx < 0) begin
                exp_bl = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1;
            end else begin
                ih = idx % 14;
                iv = (idx / 14) % 8;
                exp_bl = (ih < 8) && (iv < 4);
                exp_hs = !((ih >= 10) && (ih < 13));
                exp_vs = !((iv >= 5) && (iv < 7));
            end
            checks++;
            if ({ifs.pix_req, ifs.frame_start, ifs.line_start, bls, hss, vss} !==
                {exp_req, exp_fs, exp_ls, exp_bl, exp_hs, exp_vs}) begin
                errors++;
                per_cycle_err++;
                $display("FAIL small_cycle %0d: got req/fs/ls/bl/hs/vs=%b%b%b%b%b%b need %b%b%b%b%b%b", k,
                         ifs.pix_req, ifs.frame_start, ifs.line_start, bls, hss, vss,
                         exp_req, exp_fs, exp_ls, exp_bl, exp_hs, exp_vs);
            end
            if (ifs.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
                fs_last = k;
            end
            if (k < 112 && ifs.line_start === 1'b1) ls_f0++;
            if (k >= 3 && k < 115) begin
                if (vss === 1'b0) begin
                    vs_low++;
                    if (vs_fall < 0) vs_fall = k;
                    if (bls === 1'b1) bl_in_vs++;
                end
            end
        end
        checks++;
        if (fs_cnt !== 3 || fs_first !== 0 || fs_last - fs_first !== 224) begin
            errors++;
            $display("FAIL small_frame_period: got count=%0d first=%0d span=%0d need 3 0 224",
                     fs_cnt, fs_first, fs_last - fs_first);
        end
        checks++;
        if (ls_f0 !== 4) begin
            errors++;
            $display("FAIL small_line_starts: got %0d need 4", ls_f0);
        end
        checks++;
        if (vs_fall !== 73 || vs_low !== 28 || bl_in_vs !== 0) begin
            errors++;
            $display("FAIL small_vs: got fall=%0d low=%0d blank_in_vs=%0d need 73 28 0",
                     vs_fall, vs_low, bl_in_vs);
        end
    endtask

    task automatic test_data_alignment;
        if3.pix_data = 24'hFFFFFF;
        rst3 = 1'b1;
        repeat (2) step();
        rst3 = 1'b0;
        for (int k = 0; k < AL_N; k++) begin
            int idx, ih;
            logic [27:0] exp_pins;
            step();
            hist_req[k] = if3.pix_req;
            hist_x[k]   = if3.pix_x;
            hist_y[k]   = if3.pix_y;
            idx = k - 4;
            if (idx < 0) begin
                exp_pins = {1'b0, 1'b1, 1'b1, 1'b0, 24'h0};
            end else begin
                ih = idx % 1344;
                exp_pins = {hist_req[idx], !((ih >= 1048) && (ih < 1184)), 1'b1, 1'b0,
                            hist_req[idx] ? pat(hist_x[idx], hist_y[idx]) : 24'h0};
            end
            checks++;
            if ({bl3, hs3, vs3, sn3, r3, g3, b3} !== exp_pins) begin
                errors++;
                $display("FAIL align cycle %0d: got bl/hs/vs/sn/rgb=%b%b%b%b/%h need %b%b%b%b/%h", k,
                         bl3, hs3, vs3, sn3, {r3, g3, b3}, exp_pins[27], exp_pins[26],
                         exp_pins[25], exp_pins[24], exp_pins[23:0]);
            end
            // Data for the request three cycles back, valid for the next edge.
            if (k >= 3 && hist_req[k-3] === 1'b1)
                if3.pix_data = pat(hist_x[k-3], hist_y[k-3]);
            else
                if3.pix_data = 24'($urandom);
        end
    endtask

    task automatic test_lock_loss;
        reset_d0();
        for (int k = 0; k <= 2 * 1344 + 500; k++) step();
        checks++;
        if ({if0.pix_req, if0.pix_x, if0.pix_y} !== {1'b1, 11'd500, 10'd2}) begin
            errors++;
            $display("FAIL lock_pre: got req=%b x=%0d y=%0d need 1 500 2", if0.pix_req, if0.pix_x, if0.pix_y);
        end
        lock0 = 1'b0;
        step();
        checks++;
        if ({if0.pix_req, if0.pix_x, if0.pix_y, if0.frame_start, if0.line_start,
             hs0, vs0, bl0, r0, g0, b0} !== {24'h0, 1'b1, 1'b1, 1'b0, 24'h0}) begin
            errors++;
            $display("FAIL lock_drop: got req=%b x=%0d y=%0d hs=%b vs=%b bl=%b rgb=%h need 0 0 0 1 1 0 000000",
                     if0.pix_req, if0.pix_x, if0.pix_y, hs0, vs0, bl0, {r0, g0, b0});
        end
        repeat (9) step();
        checks++;
        if ({if0.pix_req, bl0, hs0} !== 3'b001) begin
            errors++;
            $display("FAIL lock_hold: got req=%b bl=%b hs=%b need 0 0 1", if0.pix_req, bl0, hs0);
        end
        lock0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 0) begin
                checks++;
                if ({if0.pix_req, if0.pix_x, if0.pix_y, if0.frame_start} !== {1'b1, 21'h0, 1'b1}) begin
                    errors++;
                    $display("FAIL relock_first: got req=%b x=%0d y=%0d fs=%b need 1 0 0 1",
                             if0.pix_req, if0.pix_x, if0.pix_y, if0.frame_start);
                end
            end
            if (k == 2) begin
                checks++;
                if (bl0 !== 1'b0) begin
                    errors++;
                    $display("FAIL relock_flush: got blank_n=%b need 0", bl0);
                end
            end
            if (k == 3) begin
                checks++;
                if ({bl0, r0, g0, b0} !== {1'b1, 24'h123456}) begin
                    errors++;
                    $display("FAIL relock_pixel: got blank_n=%b rgb=%h need 1 123456", bl0, {r0, g0, b0});
                end
            end
        end
    endtask

    initial begin
        if0.pix_data = 24'h123456;
        ifs.pix_data = 24'h000000;
        if3.pix_data = 24'h000000;
        #1;
        test_reset();
        test_line_timing();
        test_frame_timing();
        test_data_alignment();
        test_lock_loss();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
